// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-count link (counter and decoder blocks).
//   gray_state_t : receive-side tracking state (WAIT_REF, TRACK)
//   gray2bin()   : Gray-to-binary conversion on a MAX_W-bit, zero-extended vector
//   popcount()   : number of set bits in a MAX_W-bit vector
// Narrower counts are zero-extended to MAX_W before these functions are called.
// The extra upper zeros do not change either result.
package gray_pkg;

  localparam int MAX_W = 16;
  localparam int POP_W = 5;  // enough to hold a count of 0..16

  typedef enum logic [0:0] {
    WAIT_REF = 1'b0,
    TRACK    = 1'b1
  } gray_state_t;

  // Binary bit i is the XOR of every Gray bit from i up to the MSB.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded bus.
// A Gray source changes one bit per step, so a per-bit synchroniser is safe.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset; clears every stage to 0
//   i_d      asynchronous Gray-coded input
//   o_q      output of the last stage (SYNC_STAGES cycles after i_d)
module gray_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_decoder.sv
// Receive-side decoder for a Gray-coded count.
// The block synchronises gray_in and converts it to binary. It strobes
// bin_valid each time the value changes and reports the step direction.
// It also flags steps where more than one Gray bit changed.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   en          1 = track input; 0 = hold outputs and drop the reference
//   gray_in     Gray-coded count (asynchronous to clk)
//   clr_err     1-cycle pulse; clears err_sticky (and err_count)
//   bin_out     decoded binary value (registered)
//   bin_valid   1-cycle pulse when bin_out takes a new value
//   dir_up      1 = last step was +1 mod 2^WIDTH; 0 = -1, reference load or error
//   step_err    1-cycle pulse when more than one Gray bit changed
//   err_sticky  set by step_err, held until clr_err
//   err_count   saturating step-error count
// Optional feature: define GRAY_DEC_ERRCNT_EN to build the err_count counter.
// When the macro is undefined, err_count is tied to 0.
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir_up,
  output logic                 step_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] w_g_s;
  logic [MAX_W-1:0] w_g_s_ext;
  logic [MAX_W-1:0] w_g_prev_ext;
  logic [WIDTH-1:0] w_bin_new;
  logic [WIDTH-1:0] w_bin_old;
  logic [WIDTH-1:0] w_bin_diff;
  logic [POP_W-1:0] w_dist;
  logic             w_changed;
  logic             w_step_up;
  logic             w_err_evt;

  gray_state_t      r_state;
  logic [WIDTH-1:0] r_g_prev;
  logic [WIDTH-1:0] r_bin_out;
  logic             r_bin_valid;
  logic             r_dir_up;
  logic             r_step_err;
  logic             r_err_sticky;

  gray_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (gray_in),
    .o_q    (w_g_s)
  );

  always_comb begin
    w_g_s_ext                = '0;
    w_g_prev_ext             = '0;
    w_g_s_ext[WIDTH-1:0]     = w_g_s;
    w_g_prev_ext[WIDTH-1:0]  = r_g_prev;
  end

  assign w_bin_new  = WIDTH'(gray2bin(w_g_s_ext));
  assign w_bin_old  = WIDTH'(gray2bin(w_g_prev_ext));
  // Modular subtraction, so the wrap max -> 0 counts as +1.
  assign w_bin_diff = w_bin_new - w_bin_old;
  assign w_step_up  = (w_bin_diff == WIDTH'(1));
  assign w_dist     = popcount(w_g_s_ext ^ w_g_prev_ext);
  assign w_changed  = (w_g_s != r_g_prev);
  // A change during the reference-load cycle is never treated as an error.
  assign w_err_evt  = en && (r_state == TRACK) && w_changed && (w_dist != POP_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= WAIT_REF;
      r_g_prev     <= '0;
      r_bin_out    <= '0;
      r_bin_valid  <= 1'b0;
      r_dir_up     <= 1'b0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_g_prev    <= w_g_s;
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;

      // A new error takes priority over a clear in the same cycle.
      if (w_err_evt) begin
        r_err_sticky <= 1'b1;
      end else if (clr_err) begin
        r_err_sticky <= 1'b0;
      end

      if (!en) begin
        r_state <= WAIT_REF;
      end else begin
        case (r_state)
          WAIT_REF: begin
            r_bin_out   <= w_bin_new;
            r_bin_valid <= 1'b1;
            r_dir_up    <= 1'b0;
            r_state     <= TRACK;
          end
          TRACK: begin
            if (w_changed) begin
              r_bin_out   <= w_bin_new;
              r_bin_valid <= 1'b1;
              if (w_err_evt) begin
                r_step_err <= 1'b1;
                r_dir_up   <= 1'b0;
              end else begin
                r_dir_up   <= w_step_up;
              end
            end
          end
          default: r_state <= WAIT_REF;
        endcase
      end
    end
  end

`ifdef GRAY_DEC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (clr_err) begin
      // Clear, then count the error arriving in the same cycle.
      r_err_count <= w_err_evt ? ERR_CNT_W'(1) : '0;
    end else if (w_err_evt && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign bin_out    = r_bin_out;
  assign bin_valid  = r_bin_valid;
  assign dir_up     = r_dir_up;
  assign step_err   = r_step_err;
  assign err_sticky = r_err_sticky;

endmodule
